// File: rtl/money_pkg.sv
// Shared definitions for the money collector: state encoding, error codes,
// default denomination table and a small index-width helper.
package money_pkg;

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_REFUND  = 1'b1
    } state_e;

    localparam logic [3:0] ERR_NONE      = 4'd0;
    localparam logic [3:0] ERR_NOT_ONEHOT = 4'd1;
    localparam logic [3:0] ERR_CNT_OVF   = 4'd2;
    localparam logic [3:0] ERR_TOTAL_OVF = 4'd3;
    localparam logic [3:0] ERR_FUNDS     = 4'd4;
    localparam logic [3:0] ERR_NO_CHANGE = 4'd5;
    localparam logic [3:0] ERR_BUSY      = 4'd6;

    // Index 0 (LSBs) is the smallest coin; values ascend with the index.
    localparam logic [63:0] DEF_DENOM_VAL = {16'd5000, 16'd2000, 16'd1000, 16'd500};

    function automatic int unsigned idx_width(input int unsigned n);
        if (n > 32'd1) begin
            return $clog2(n);
        end else begin
            return 32'd1;
        end
    endfunction

endpackage

// File: rtl/money_collector_change_select.sv
// Combinational change picker: highest denomination index that is both in
// escrow and no larger than the remaining credit.
module change_select
    import money_pkg::*;
#(
    parameter int unsigned NUM_DENOM = 4,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned TOTAL_W   = 16,
    parameter logic [NUM_DENOM*TOTAL_W-1:0] DENOM_VAL = DEF_DENOM_VAL,
    localparam int unsigned IDX_W    = idx_width(NUM_DENOM)
) (
    input  logic [NUM_DENOM*CNT_W-1:0] counts,
    input  logic [TOTAL_W-1:0]         total,
    output logic [IDX_W-1:0]           idx,
    output logic                       found
);

    // Ascending scan so the last qualifying (highest) index wins.
    always_comb begin
        idx   = {IDX_W{1'b0}};
        found = 1'b0;
        for (int i = 0; i < NUM_DENOM; i++) begin
            if ((counts[i*CNT_W +: CNT_W] != {CNT_W{1'b0}}) &&
                (DENOM_VAL[i*TOTAL_W +: TOTAL_W] <= total)) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/money_collector.sv
// Coin escrow with credit total, vend handshake and greedy change refund.
// All outputs are registered; the refund item is chosen from next-state values.
module money_collector
    import money_pkg::*;
#(
    parameter int unsigned NUM_DENOM = 4,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned TOTAL_W   = 16,
    parameter logic [NUM_DENOM*TOTAL_W-1:0] DENOM_VAL = DEF_DENOM_VAL
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       money_valid,
    input  logic [NUM_DENOM-1:0]       money_type,
    input  logic                       vend_req,
    input  logic [TOTAL_W-1:0]         vend_price,
    output logic                       vend_ack,
    output logic                       vend_nack,
    input  logic                       refund_req,
    output logic                       refund_valid,
    input  logic                       refund_ready,
    output logic [NUM_DENOM-1:0]       refund_type,
    output logic                       busy,
    output logic [3:0]                 error,
    output logic [TOTAL_W-1:0]         total,
    output logic [NUM_DENOM*CNT_W-1:0] counts
);

    localparam int unsigned IDX_W = idx_width(NUM_DENOM);

    function automatic logic is_onehot(input logic [NUM_DENOM-1:0] v);
        return (v != {NUM_DENOM{1'b0}}) &&
               ((v & (v - NUM_DENOM'(1'b1))) == {NUM_DENOM{1'b0}});
    endfunction

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_DENOM-1:0] v);
        logic [IDX_W-1:0] r;
        r = {IDX_W{1'b0}};
        for (int i = 0; i < NUM_DENOM; i++) begin
            if (v[i]) begin
                r = IDX_W'(i);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    state_e                     state_r, state_pre_s, state_nxt_s;
    logic [TOTAL_W-1:0]         total_r, total_nxt_s;
    logic [NUM_DENOM*CNT_W-1:0] counts_r, counts_nxt_s;
    logic [3:0]                 error_r, error_pre_s, error_nxt_s;
    logic                       vend_ack_r, vend_ack_nxt_s;
    logic                       vend_nack_r, vend_nack_nxt_s;
    logic                       refund_valid_r, refund_valid_nxt_s;
    logic [NUM_DENOM-1:0]       refund_type_r, refund_type_nxt_s;
    logic                       busy_r, busy_nxt_s;

    logic [IDX_W-1:0]   ins_idx_s, cur_idx_s, sel_idx_s;
    logic [TOTAL_W-1:0] ins_val_s, cur_val_s;
    logic [CNT_W-1:0]   ins_cnt_s, cur_cnt_s;
    logic [TOTAL_W:0]   ins_sum_s;
    logic               sel_found_s;

    assign ins_idx_s = onehot_to_idx(money_type);
    assign ins_val_s = DENOM_VAL[int'(ins_idx_s)*TOTAL_W +: TOTAL_W];
    assign ins_cnt_s = counts_r[int'(ins_idx_s)*CNT_W +: CNT_W];
    assign ins_sum_s = {1'b0, total_r} + {1'b0, ins_val_s};
    assign cur_idx_s = onehot_to_idx(refund_type_r);
    assign cur_val_s = DENOM_VAL[int'(cur_idx_s)*TOTAL_W +: TOTAL_W];
    assign cur_cnt_s = counts_r[int'(cur_idx_s)*CNT_W +: CNT_W];

    // Insertion / vend / refund-step datapath; state_pre_s is the state before change selection.
    always_comb begin
        logic [3:0] ins_code;
        logic       ins_ok;
        logic       vend_ok;
        logic       refund_go;
        total_nxt_s     = total_r;
        counts_nxt_s    = counts_r;
        error_pre_s     = error_r;
        vend_ack_nxt_s  = 1'b0;
        vend_nack_nxt_s = 1'b0;
        state_pre_s     = ST_COLLECT;
        ins_code        = ERR_NONE;
        ins_ok          = 1'b0;
        vend_ok         = 1'b0;
        refund_go       = 1'b0;
        case (state_r)
            ST_COLLECT: begin
                refund_go = refund_req && (total_r != {TOTAL_W{1'b0}});
                if (!money_valid) begin
                    ins_code = ERR_NONE;
                end else if (!is_onehot(money_type)) begin
                    ins_code = ERR_NOT_ONEHOT;
                end else if (&ins_cnt_s) begin
                    ins_code = ERR_CNT_OVF;
                end else if (ins_sum_s[TOTAL_W]) begin
                    ins_code = ERR_TOTAL_OVF;
                end else begin
                    ins_ok = 1'b1;
                end
                // Vend is judged on the pre-insertion credit.
                vend_ok         = vend_req && !refund_go && (total_r >= vend_price);
                vend_ack_nxt_s  = vend_ok;
                vend_nack_nxt_s = vend_req && !vend_ok;
                total_nxt_s     = total_r + (ins_ok ? ins_val_s : {TOTAL_W{1'b0}})
                                          - (vend_ok ? vend_price : {TOTAL_W{1'b0}});
                if (ins_ok) begin
                    counts_nxt_s[int'(ins_idx_s)*CNT_W +: CNT_W] = ins_cnt_s + CNT_W'(1'b1);
                end else begin
                    counts_nxt_s = counts_r;
                end
                if (ins_code != ERR_NONE) begin
                    error_pre_s = ins_code;
                end else if (vend_req && !refund_go && !vend_ok) begin
                    error_pre_s = ERR_FUNDS;
                end else if (ins_ok) begin
                    error_pre_s = ERR_NONE;
                end else begin
                    error_pre_s = error_r;
                end
                state_pre_s = refund_go ? ST_REFUND : ST_COLLECT;
            end
            ST_REFUND: begin
                vend_nack_nxt_s = vend_req;
                if (money_valid) begin
                    error_pre_s = ERR_BUSY;
                end else begin
                    error_pre_s = error_r;
                end
                if (refund_valid_r && refund_ready) begin
                    counts_nxt_s[int'(cur_idx_s)*CNT_W +: CNT_W] = cur_cnt_s - CNT_W'(1'b1);
                    total_nxt_s = total_r - cur_val_s;
                end else begin
                    total_nxt_s = total_r;
                end
                state_pre_s = ST_REFUND;
            end
            default: begin
                state_pre_s = ST_COLLECT;
            end
        endcase
    end

    change_select #(
        .NUM_DENOM (NUM_DENOM),
        .CNT_W     (CNT_W),
        .TOTAL_W   (TOTAL_W),
        .DENOM_VAL (DENOM_VAL)
    ) u_change_select (
        .counts (counts_nxt_s),
        .total  (total_nxt_s),
        .idx    (sel_idx_s),
        .found  (sel_found_s)
    );

    // Refund item selection on next-state values so accepted items stream back-to-back.
    always_comb begin
        state_nxt_s        = ST_COLLECT;
        error_nxt_s        = error_pre_s;
        refund_valid_nxt_s = 1'b0;
        refund_type_nxt_s  = {NUM_DENOM{1'b0}};
        busy_nxt_s         = 1'b0;
        if (state_pre_s != ST_REFUND) begin
            state_nxt_s = ST_COLLECT;
        end else if (total_nxt_s == {TOTAL_W{1'b0}}) begin
            state_nxt_s = ST_COLLECT;
        end else if (sel_found_s) begin
            state_nxt_s        = ST_REFUND;
            refund_valid_nxt_s = 1'b1;
            refund_type_nxt_s  = NUM_DENOM'(1'b1) << sel_idx_s;
            busy_nxt_s         = 1'b1;
        end else begin
            state_nxt_s = ST_COLLECT;
            error_nxt_s = ERR_NO_CHANGE;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= ST_COLLECT;
            total_r        <= {TOTAL_W{1'b0}};
            counts_r       <= {(NUM_DENOM*CNT_W){1'b0}};
            error_r        <= ERR_NONE;
            vend_ack_r     <= 1'b0;
            vend_nack_r    <= 1'b0;
            refund_valid_r <= 1'b0;
            refund_type_r  <= {NUM_DENOM{1'b0}};
            busy_r         <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            total_r        <= total_nxt_s;
            counts_r       <= counts_nxt_s;
            error_r        <= error_nxt_s;
            vend_ack_r     <= vend_ack_nxt_s;
            vend_nack_r    <= vend_nack_nxt_s;
            refund_valid_r <= refund_valid_nxt_s;
            refund_type_r  <= refund_type_nxt_s;
            busy_r         <= busy_nxt_s;
        end
    end

    assign vend_ack     = vend_ack_r;
    assign vend_nack    = vend_nack_r;
    assign refund_valid = refund_valid_r;
    assign refund_type  = refund_type_r;
    assign busy         = busy_r;
    assign error        = error_r;
    assign total        = total_r;
    assign counts       = counts_r;

endmodule

// File: tb/tb_money_collector.sv
// Directed bench for money_collector: a behavioural model pushes expected
// outputs to a scoreboard each cycle; they are popped and checked after the edge.
module tb_money_collector;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        money_valid = 1'b0;
    logic [3:0]  money_type = 4'd0;
    logic        vend_req = 1'b0;
    logic [15:0] vend_price = 16'd0;
    logic        vend_ack, vend_nack;
    logic        refund_req = 1'b0;
    logic        refund_valid;
    logic        refund_ready = 1'b0;
    logic [3:0]  refund_type;
    logic        busy;
    logic [3:0]  error;
    logic [15:0] total;
    logic [31:0] counts;

    always #5 clock = ~clock;

    money_collector dut (
        .clock        (clock),
        .reset        (reset),
        .money_valid  (money_valid),
        .money_type   (money_type),
        .vend_req     (vend_req),
        .vend_price   (vend_price),
        .vend_ack     (vend_ack),
        .vend_nack    (vend_nack),
        .refund_req   (refund_req),
        .refund_valid (refund_valid),
        .refund_ready (refund_ready),
        .refund_type  (refund_type),
        .busy         (busy),
        .error        (error),
        .total        (total),
        .counts       (counts)
    );

    typedef struct {
        logic [15:0] total;
        logic [31:0] counts;
        logic [3:0]  error;
        logic        vack;
        logic        vnack;
        logic        rvalid;
        logic [3:0]  rtype;
        logic        busy;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    int m_total;
    int m_cnt[4];
    int m_err;
    bit m_busy;
    int m_item;
    int m_val[4] = '{500, 1000, 2000, 5000};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_select();
        bit found;
        found = 1'b0;
        if (m_busy) begin
            if (m_total == 0) begin
                m_busy = 1'b0;
            end else begin
                for (int i = 3; i >= 0; i--) begin
                    if (!found && m_cnt[i] > 0 && m_val[i] <= m_total) begin
                        m_item = i;
                        found  = 1'b1;
                    end
                end
                if (!found) begin
                    m_err  = 5;
                    m_busy = 1'b0;
                end
            end
        end
    endtask

    task automatic step(input string tag, input bit rst, input bit iv, input logic [3:0] it,
                        input bit vr, input int vp, input bit rr, input bit rd);
        exp_t e;
        bit   vack, vnack, go;
        int   idx, code, pre;
        vack  = 1'b0;
        vnack = 1'b0;
        reset = rst; money_valid = iv; money_type = it;
        vend_req = vr; vend_price = vp[15:0]; refund_req = rr; refund_ready = rd;
        if (rst) begin
            m_total = 0; m_err = 0; m_busy = 1'b0; m_item = 0;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end else if (!m_busy) begin
            idx  = -1;
            code = 0;
            pre  = m_total;
            go   = rr && (pre > 0);
            if (iv) begin
                for (int i = 0; i < 4; i++) if (it == (4'b0001 << i)) idx = i;
                if (idx < 0) code = 1;
                else if (m_cnt[idx] == 255) code = 2;
                else if (pre + m_val[idx] > 65535) code = 3;
            end
            if (iv && code == 0) begin
                m_cnt[idx]++;
                m_total += m_val[idx];
                m_err = 0;
            end
            if (vr) begin
                if (!go && pre >= vp) begin
                    vack = 1'b1;
                    m_total -= vp;
                end else begin
                    vnack = 1'b1;
                    if (!go) m_err = 4;
                end
            end
            if (code != 0) m_err = code;
            if (go) m_busy = 1'b1;
        end else begin
            if (iv) m_err = 6;
            if (vr) vnack = 1'b1;
            if (rd) begin
                m_cnt[m_item]--;
                m_total -= m_val[m_item];
            end
        end
        model_select();
        e.total  = 16'(m_total);
        e.counts = {8'(m_cnt[3]), 8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[0])};
        e.error  = 4'(m_err);
        e.vack   = vack;
        e.vnack  = vnack;
        e.rvalid = m_busy;
        e.rtype  = m_busy ? (4'b0001 << m_item) : 4'b0000;
        e.busy   = m_busy;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        e = sb_q.pop_front();
        chk({tag, "_total"},  32'(total),        32'(e.total));
        chk({tag, "_counts"}, counts,            e.counts);
        chk({tag, "_error"},  32'(error),        32'(e.error));
        chk({tag, "_vack"},   32'(vend_ack),     32'(e.vack));
        chk({tag, "_vnack"},  32'(vend_nack),    32'(e.vnack));
        chk({tag, "_rvalid"}, 32'(refund_valid), 32'(e.rvalid));
        chk({tag, "_rtype"},  32'(refund_type),  32'(e.rtype));
        chk({tag, "_busy"},   32'(busy),         32'(e.busy));
    endtask

    task automatic ins(input string tag, input logic [3:0] it);
        step(tag, 1'b0, 1'b1, it, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic idle(input string tag, input bit rd);
        step(tag, 1'b0, 1'b0, 4'b0000, 1'b0, 0, 1'b0, rd);
    endtask

    initial begin
        @(posedge clock);
        #1;
        step("rst", 1'b1, 1'b0, 4'b0000, 1'b0, 0, 1'b0, 1'b0);
        step("rst", 1'b1, 1'b1, 4'b0001, 1'b1, 0, 1'b1, 1'b1);

        // Four denominations in ascending order.
        ins("ins500", 4'b0001);
        ins("ins1000", 4'b0010);
        ins("ins2000", 4'b0100);
        ins("ins5000", 4'b1000);
        chk("sum_total", 32'(total), 32'd8500);
        chk("sum_counts", counts, 32'h01010101);
        chk("sum_error", 32'(error), 32'd0);

        // Non-one-hot insertions.
        ins("ins1111", 4'b1111);
        chk("multi_error", 32'(error), 32'd1);
        ins("ins0000", 4'b0000);
        chk("zero_error", 32'(error), 32'd1);
        chk("zero_total", 32'(total), 32'd8500);

        // Vend success then insufficient funds.
        step("rst", 1'b1, 1'b0, 4'b0000, 1'b0, 0, 1'b0, 1'b0);
        ins("a2000", 4'b0100);
        ins("b2000", 4'b0100);
        step("vend1500", 1'b0, 1'b0, 4'b0000, 1'b1, 1500, 1'b0, 1'b0);
        chk("vend_ack", 32'(vend_ack), 32'd1);
        chk("vend_total", 32'(total), 32'd2500);
        step("vend3000", 1'b0, 1'b0, 4'b0000, 1'b1, 3000, 1'b0, 1'b0);
        chk("vend_nack", 32'(vend_nack), 32'd1);
        chk("vend_err", 32'(error), 32'd4);
        chk("vend_cnt", counts, 32'h00020000);

        // Greedy refund with ready held high.
        step("rst", 1'b1, 1'b0, 4'b0000, 1'b0, 0, 1'b0, 1'b0);
        ins("r5000", 4'b1000);
        ins("r500a", 4'b0001);
        ins("r500b", 4'b0001);
        step("rfreq", 1'b0, 1'b0, 4'b0000, 1'b0, 0, 1'b1, 1'b1);
        chk("rf_first", 32'(refund_type), 32'h8);
        idle("rf1", 1'b1);
        chk("rf_second", 32'(refund_type), 32'h1);
        idle("rf2", 1'b1);
        chk("rf_third", 32'(refund_type), 32'h1);
        idle("rf3", 1'b1);
        chk("rf_done_total", 32'(total), 32'd0);
        chk("rf_done_busy", 32'(busy), 32'd0);
        idle("rf4", 1'b1);

        // Exact change unavailable.
        step("rst", 1'b1, 1'b0, 4'b0000, 1'b0, 0, 1'b0, 1'b0);
        ins("x2000", 4'b0100);
        step("xvend", 1'b0, 1'b0, 4'b0000, 1'b1, 1500, 1'b0, 1'b0);
        step("xrefund", 1'b0, 1'b0, 4'b0000, 1'b0, 0, 1'b1, 1'b0);
        chk("nochg_err", 32'(error), 32'd5);
        chk("nochg_total", 32'(total), 32'd500);
        chk("nochg_valid", 32'(refund_valid), 32'd0);

        // Stalled refund, activity during REFUND, then reset mid-refund.
        ins("s5000", 4'b1000);
        ins("s1000", 4'b0010);
        step("s_ref_vend", 1'b0, 1'b0, 4'b0000, 1'b1, 100, 1'b1, 1'b0);
        chk("s_ref_vnack", 32'(vend_nack), 32'd1);
        idle("s_hold", 1'b0);
        chk("s_hold_type", 32'(refund_type), 32'h8);
        step("s_busy_ins", 1'b0, 1'b1, 4'b0001, 1'b1, 10, 1'b1, 1'b0);
        chk("s_busy_err", 32'(error), 32'd6);
        idle("s_take", 1'b1);
        step("s_rst", 1'b1, 1'b0, 4'b0000, 1'b0, 0, 1'b0, 1'b0);
        chk("s_rst_valid", 32'(refund_valid), 32'd0);
        chk("s_rst_busy", 32'(busy), 32'd0);
        chk("s_rst_counts", counts, 32'd0);

        // Count wrap: keep credit at 500 by vending alongside each insertion.
        ins("c_first", 4'b0001);
        for (int n = 0; n < 254; n++) begin
            step("c_loop", 1'b0, 1'b1, 4'b0001, 1'b1, 500, 1'b0, 1'b0);
        end
        chk("c_full", counts, 32'h000000FF);
        ins("c_wrap", 4'b0001);
        chk("c_wrap_err", 32'(error), 32'd2);
        ins("c_prio", 4'b0011);
        chk("c_prio_err", 32'(error), 32'd1);

        // Total wrap.
        step("rst", 1'b1, 1'b0, 4'b0000, 1'b0, 0, 1'b0, 1'b0);
        for (int n = 0; n < 13; n++) begin
            ins("t_fill", 4'b1000);
        end
        ins("t_wrap", 4'b0100);
        chk("t_wrap_err", 32'(error), 32'd3);
        chk("t_wrap_total", 32'(total), 32'd65000);
        ins("t_fit", 4'b0001);
        chk("t_fit_total", 32'(total), 32'd65500);
        step("t_ref_zero", 1'b1, 1'b0, 4'b0000, 1'b0, 0, 1'b0, 1'b0);
        step("t_ref_empty", 1'b0, 1'b0, 4'b0000, 1'b0, 0, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/money_collector.md
MONEY_COLLECTOR -- requirements
Module: money_collector

Interface
REQ-001 Parameter NUM_DENOM, default 4: number of accepted denominations.
REQ-002 Parameter CNT_W, default 8: width of each per-denomination count.
REQ-003 Parameter TOTAL_W, default 16: width of the credit total.
REQ-004 Parameter DENOM_VAL, default {5000,2000,1000,500}: packed TOTAL_W-bit values; index 0 is the smallest value and values ascend by index.
REQ-005 clock  in  1  sole clock; all state changes on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 money_valid  in  1  an insertion is offered this cycle.
REQ-008 money_type  in  NUM_DENOM  one-hot denomination of the insertion.
REQ-009 vend_req  in  1  single-cycle purchase request.
REQ-010 vend_price  in  TOTAL_W  price, sampled when vend_req=1.
REQ-011 vend_ack / vend_nack  out  1  single-cycle purchase result.
REQ-012 refund_req  in  1  single-cycle request to return the full credit.
REQ-013 refund_valid  out  1  a returned item is presented on refund_type.
REQ-014 refund_ready  in  1  the dispenser takes the item.
REQ-015 refund_type  out  NUM_DENOM  one-hot denomination being returned.
REQ-016 busy  out  1  high while in REFUND.
REQ-017 error  out  4  last error code.
REQ-018 total  out  TOTAL_W  current credit.
REQ-019 counts  out  NUM_DENOM*CNT_W  packed escrow count per denomination; index 0 is the LSBs.

Function
REQ-020 The block SHALL have two states: COLLECT and REFUND; it enters COLLECT on reset.
REQ-021 In COLLECT, a valid one-hot insertion SHALL add DENOM_VAL[i] to total and increment counts[i] in the same cycle, with results visible one cycle later; error SHALL then clear to 0.
REQ-022 An insertion whose money_type is not one-hot, including all-zero, SHALL be rejected with error=1 and no state change.
REQ-023 An insertion that would wrap counts[i] SHALL be rejected with error=2.
REQ-024 An insertion that would wrap total SHALL be rejected with error=3.
REQ-025 Error checks SHALL take priority in the order 1, 2, 3.
REQ-026 A vend_req in COLLECT with total >= vend_price SHALL subtract the price from total, pulse vend_ack the next cycle, and leave counts unchanged.
REQ-027 A vend_req in COLLECT with total < vend_price SHALL pulse vend_nack the next cycle, set error=4, and change nothing else.
REQ-028 When money_valid and vend_req are both high in the same cycle, the vend SHALL be evaluated against the pre-insertion total, and both effects SHALL apply if each is individually legal.
REQ-029 A refund_req in COLLECT with total>0 SHALL enter REFUND the next cycle; with total=0 it SHALL be ignored.
REQ-030 refund_req SHALL take priority over a vend_req in the same cycle; the vend is then answered with vend_nack.
REQ-031 In REFUND, the block SHALL select the highest i with counts[i]>0 and DENOM_VAL[i] <= total, and hold refund_valid=1 with refund_type=onehot(i).
REQ-032 On refund_valid & refund_ready, the block SHALL decrement counts[i], subtract DENOM_VAL[i] from total, and reselect on the next cycle.
REQ-033 refund_valid and refund_type SHALL remain stable until accepted.
REQ-034 The block SHALL return to COLLECT when total reaches 0.
REQ-035 If total>0 and no denomination qualifies, the block SHALL set error=5 (exact change unavailable), leave the residual total intact, and return to COLLECT.
REQ-036 In REFUND, insertions SHALL be rejected with error=6, vend_req SHALL be answered with vend_nack, and refund_req SHALL be ignored.

Reset
REQ-037 Reset SHALL force state=COLLECT, total=0, all counts=0, error=0, and refund_valid, vend_ack, vend_nack and busy all to 0.
REQ-038 Reset SHALL override every other input in the same cycle, including mid-REFUND, where it abandons any pending item.

Structure
REQ-039 Error codes, the state encoding and the default DENOM_VAL SHALL live in shared package money_pkg.
REQ-040 Denomination selection SHALL be a combinational sub-module, change_select: priority pick of the highest qualifying index, plus a found flag.
REQ-041 All arithmetic SHALL be unsigned TOTAL_W, with explicit overflow detection using a TOTAL_W+1 sum.

Verification
REQ-042 Insert 500, 1000, 2000, 5000 -> total=8500, counts={1,1,1,1}, error=0.
REQ-043 Insert 4'b1111, then 4'b0000 -> error=1 each time, total unchanged.
REQ-044 Insert 2000 twice, vend price 1500 -> vend_ack, total=2500; vend price 3000 -> vend_nack, error=4.
REQ-045 Holding 5000x1 and 500x2 (total 6000), refund with refund_ready held high -> returns 5000, 500, 500 on consecutive cycles, then total=0 and back to COLLECT.
REQ-046 Insert 2000, vend 1500 (total 500, counts 2000x1) -> refund yields error=5, total=500, no refund_valid.
REQ-047 Assert reset while refund_valid is pending with refund_ready=0 -> next cycle all outputs are 0 and state is COLLECT; 255 insertions of 500 followed by a 256th -> error=2.
